// File: rtl/flag_unit.sv
// Condition-code register with forwarded jump resolution and a LIFO of snapshots for nested interrupts.
// Latency: ccr/depth/ovf/unf update one cycle after the inputs; jump_taken is combinational.
// Backpressure: none. Pushes while full and pops while empty are dropped and flagged sticky in ovf/unf.
module flag_unit #(
    parameter int SAVE_DEPTH = 4,
    parameter int DEPTH_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         alu_flags,
    input  logic               flags_we,
    input  logic               set_c,
    input  logic               clr_c,
    input  logic               jmp_valid,
    input  logic [1:0]         jmp_cond,
    input  logic               int_save,
    input  logic               rti_restore,
    output logic [5:0]         ccr,
    output logic               jump_taken,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf
);

    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(SAVE_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

    logic [2:0] flags_q;
    logic [2:0] w0, w1, w2;
    logic       tested;
    logic       do_restore, do_push, pop_empty, push_full;
    logic [2:0] stack [SAVE_DEPTH];
    logic       unused_rsvd;

    assign unused_rsvd = ^alu_flags[5:3];
    assign ccr         = {3'b000, flags_q};

    always_comb begin
        w0 = flags_we ? alu_flags[2:0] : flags_q;
        w1 = w0;
        if (set_c)
            w1[2] = 1'b1;
        else if (clr_c)
            w1[2] = 1'b0;

        case (jmp_cond)
            2'b00:   tested = 1'b1;
            2'b01:   tested = w1[0];
            2'b10:   tested = w1[1];
            default: tested = w1[2];
        endcase
        jump_taken = rst & jmp_valid & tested;

        // A taken conditional jump consumes the flag it tested.
        w2 = w1;
        if (jump_taken) begin
            case (jmp_cond)
                2'b01:   w2[0] = 1'b0;
                2'b10:   w2[1] = 1'b0;
                2'b11:   w2[2] = 1'b0;
                default: ;
            endcase
        end
    end

    // Restore outranks save; a simultaneous save is dropped without flagging.
    assign do_restore = rti_restore && (depth != '0);
    assign pop_empty  = rti_restore && (depth == '0);
    assign do_push    = int_save && !rti_restore && (depth != FULL);
    assign push_full  = int_save && !rti_restore && (depth == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= 3'b000;
            depth   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (do_restore) begin
                flags_q <= stack[0];
                depth   <= depth - ONE;
            end else begin
                flags_q <= w2;
                if (do_push)
                    depth <= depth + ONE;
            end
            if (pop_empty)
                unf <= 1'b1;
            if (push_full)
                ovf <= 1'b1;
        end
    end

    // Shift-register stack: entry 0 is always the most recent snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SAVE_DEPTH; i++)
                stack[i] <= 3'b000;
        end else if (do_push) begin
            stack[0] <= w2;
            for (int i = 1; i < SAVE_DEPTH; i++)
                stack[i] <= stack[i-1];
        end else if (do_restore) begin
            for (int i = 0; i < SAVE_DEPTH - 1; i++)
                stack[i] <= stack[i+1];
            stack[SAVE_DEPTH-1] <= 3'b000;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a reference model predicts each cycle's outcome, queued and compared after the edge.
module tb_flag_unit;

    localparam int SD = 4;

    typedef struct packed {
        logic [5:0] ccr;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] alu_flags = '0;
    logic       flags_we = 0, set_c = 0, clr_c = 0, jmp_valid = 0;
    logic [1:0] jmp_cond = '0;
    logic       int_save = 0, rti_restore = 0;
    logic [5:0] ccr;
    logic       jump_taken;
    logic [2:0] depth;
    logic       ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];

    // Reference model state (indexed stack, independent of the DUT's structure)
    logic [2:0] m_ccr;
    logic [2:0] m_stk [SD];
    int         m_depth;
    logic       m_ovf, m_unf;

    flag_unit #(.SAVE_DEPTH(SD), .DEPTH_W(3)) dut (
        .clk(clk), .rst(rst), .alu_flags(alu_flags), .flags_we(flags_we),
        .set_c(set_c), .clr_c(clr_c), .jmp_valid(jmp_valid), .jmp_cond(jmp_cond),
        .int_save(int_save), .rti_restore(rti_restore), .ccr(ccr),
        .jump_taken(jump_taken), .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ccr = 3'b000;
        m_depth = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < SD; i++) m_stk[i] = 3'b000;
    endtask

    // One cycle: drive at negedge, check jump_taken combinationally, queue the prediction, check after the edge.
    task automatic cyc(input logic [5:0] af, input logic we, input logic sc, input logic cc,
                       input logic jv, input logic [1:0] jc, input logic sv, input logic rr);
        logic [2:0] w, w2;
        logic       jt;
        exp_t       e, got;
        @(negedge clk);
        alu_flags = af; flags_we = we; set_c = sc; clr_c = cc;
        jmp_valid = jv; jmp_cond = jc; int_save = sv; rti_restore = rr;
        #1;
        w = we ? af[2:0] : m_ccr;
        if (sc) w[2] = 1'b1;
        else if (cc) w[2] = 1'b0;
        jt = jv && ((jc == 2'b00) || w[int'(jc) - 1]);
        w2 = w;
        if (jt && jc != 2'b00) w2[int'(jc) - 1] = 1'b0;
        chk("jump_taken", {31'b0, jump_taken}, {31'b0, jt});
        if (rr) begin
            if (m_depth > 0) begin
                m_depth--;
                m_ccr = m_stk[m_depth];
            end else begin
                m_unf = 1'b1;
                m_ccr = w2;
            end
        end else if (sv) begin
            if (m_depth < SD) begin
                m_stk[m_depth] = w2;
                m_depth++;
            end else begin
                m_ovf = 1'b1;
            end
            m_ccr = w2;
        end else begin
            m_ccr = w2;
        end
        e.ccr = {3'b000, m_ccr};
        e.depth = 3'(m_depth);
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = '{ccr: ccr, depth: depth, ovf: ovf, unf: unf};
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("ccr", {26'b0, got.ccr}, {26'b0, e.ccr});
            chk("depth", {29'b0, got.depth}, {29'b0, e.depth});
            chk("ovf", {31'b0, got.ovf}, {31'b0, e.ovf});
            chk("unf", {31'b0, got.unf}, {31'b0, e.unf});
        end
    endtask

    task automatic wr(input logic [5:0] af);
        cyc(af, 1, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic rti();
        cyc(6'b0, 0, 0, 0, 0, 2'b00, 0, 1);
    endtask

    initial begin
        model_reset();
        // Reset state, with an unconditional jump requested to show gating
        jmp_valid = 1'b1;
        #2;
        chk("rst_ccr", {26'b0, ccr}, 32'd0);
        chk("rst_depth", {29'b0, depth}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_unf", {31'b0, unf}, 32'd0);
        chk("rst_jt", {31'b0, jump_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        jmp_valid = 1'b0;

        // Reserved bits masked
        wr(6'b111_101);
        chk("mask_const", {26'b0, ccr}, 32'b000_101);

        // JZ taken clears Z; JN not taken leaves CCR alone
        wr(6'b000_001);
        cyc(6'b0, 0, 0, 0, 1, 2'b01, 0, 0);
        chk("jz_clear_const", {26'b0, ccr}, 32'd0);
        wr(6'b000_001);
        cyc(6'b0, 0, 0, 0, 1, 2'b10, 0, 0);
        chk("jn_keep_const", {26'b0, ccr}, 32'b000_001);

        // Forwarded carry into JC, then set_c beats clr_c
        wr(6'b0);
        cyc(6'b000_100, 1, 0, 0, 1, 2'b11, 0, 0);
        cyc(6'b0, 0, 1, 1, 0, 2'b00, 0, 0);
        chk("setc_wins_const", {26'b0, ccr}, 32'b000_100);

        // Push with same-cycle write, nested restore, then underflow
        wr(6'b0);
        cyc(6'b000_010, 1, 0, 0, 0, 2'b00, 1, 0);
        cyc(6'b000_100, 1, 0, 0, 0, 2'b00, 1, 0);
        wr(6'b000_001);
        rti();
        chk("rti1_const", {26'b0, ccr}, 32'b000_100);
        rti();
        chk("rti2_const", {26'b0, ccr}, 32'b000_010);
        rti();
        chk("unf_const", {31'b0, unf}, 32'd1);

        // Overflow after SD+1 pushes, then LIFO drain
        for (int i = 1; i <= SD + 1; i++)
            cyc(6'(i), 1, 0, 0, 0, 2'b00, 1, 0);
        chk("ovf_const", {31'b0, ovf}, 32'd1);
        chk("full_depth_const", {29'b0, depth}, 32'd4);
        for (int i = 0; i < SD; i++) rti();

        // Simultaneous save and restore: restore wins
        cyc(6'b000_011, 1, 0, 0, 0, 2'b00, 1, 0);
        cyc(6'b000_110, 1, 0, 0, 1, 2'b00, 1, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++)
            cyc(6'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));

        // Asynchronous reset mid-cycle with two snapshots held
        wr(6'b0);
        rti(); rti(); rti(); rti(); rti();
        cyc(6'b000_111, 1, 0, 0, 0, 2'b00, 1, 0);
        cyc(6'b000_111, 1, 0, 0, 0, 2'b00, 1, 0);
        chk("pre_rst_depth", {29'b0, depth}, 32'd2);
        @(negedge clk);
        alu_flags = '0; flags_we = 0; set_c = 0; clr_c = 0;
        jmp_valid = 1'b1; jmp_cond = 2'b00; int_save = 0; rti_restore = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ccr", {26'b0, ccr}, 32'd0);
        chk("arst_depth", {29'b0, depth}, 32'd0);
        chk("arst_ovf", {31'b0, ovf}, 32'd0);
        chk("arst_unf", {31'b0, unf}, 32'd0);
        chk("arst_jt", {31'b0, jump_taken}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        jmp_valid = 1'b0;
        // Snapshots discarded: an RTI now underflows
        rti();
        chk("post_rst_unf", {31'b0, unf}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
